// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel clock-enable divider, h/v counters and
// registered sync/blank/strobe decode. Define VGA_TESTPAT_EN to add an 8-bar colour test pattern.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic          vga_clk,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] pixelx,
    output logic [CW-1:0] pixely,
    output logic          active,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TESTPAT_EN
    ,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [CW-1:0] hcnt_nxt;
    logic [CW-1:0] vcnt_nxt;
    logic          h_wrap;
    logic          active_nxt;
    logic          hsync_nxt;
    logic          vsync_nxt;

    assign pix_ce = en && (div_cnt == DIV_LAST);
    assign blank  = active;
    assign sync   = 1'b0;

    always_comb begin
        div_nxt  = div_cnt;
        hcnt_nxt = pixelx;
        vcnt_nxt = pixely;
        h_wrap   = 1'b0;
        if (en) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
        if (pix_ce) begin
            if (pixelx == H_LAST) begin
                hcnt_nxt = '0;
                h_wrap   = 1'b1;
                vcnt_nxt = (pixely == V_LAST) ? '0 : pixely + CW'(1);
            end else begin
                hcnt_nxt = pixelx + CW'(1);
            end
        end
    end

    // Decode from next-state counters so registered outputs line up with pixelx/pixely.
    always_comb begin
        active_nxt = (hcnt_nxt < H_ACT_C) && (vcnt_nxt < V_ACT_C);
        hsync_nxt  = ((hcnt_nxt >= HS_START) && (hcnt_nxt < HS_END)) ? HS_ON : ~HS_ON;
        vsync_nxt  = ((vcnt_nxt >= VS_START) && (vcnt_nxt < VS_END)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            vga_clk     <= 1'b0;
            pixelx      <= '0;
            pixely      <= '0;
            active      <= 1'b1;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            vga_clk     <= (div_nxt >= DIV_HALF);
            line_start  <= pix_ce && h_wrap;
            frame_start <= pix_ce && h_wrap && (vcnt_nxt == '0);
            if (pix_ce) begin
                pixelx <= hcnt_nxt;
                pixely <= vcnt_nxt;
                active <= active_nxt;
                hsync  <= hsync_nxt;
                vsync  <= vsync_nxt;
            end
        end
    end

`ifdef VGA_TESTPAT_EN
    logic [CW+2:0] hx8;
    logic [2:0]    bar_nxt;
    logic [2:0]    rgb_bits;

    // bar = floor(hcnt*8/H_ACTIVE), found by comparing against the seven bar edges.
    always_comb begin
        hx8     = {hcnt_nxt, 3'b000};
        bar_nxt = '0;
        for (int i = 1; i < 8; i++) begin
            if (hx8 >= (CW+3)'(i * H_ACTIVE)) begin
                bar_nxt = 3'(i);
            end
        end
    end

    always_comb begin
        case (bar_nxt)
            3'd0:    rgb_bits = 3'b111;
            3'd1:    rgb_bits = 3'b110;
            3'd2:    rgb_bits = 3'b011;
            3'd3:    rgb_bits = 3'b010;
            3'd4:    rgb_bits = 3'b101;
            3'd5:    rgb_bits = 3'b100;
            3'd6:    rgb_bits = 3'b001;
            default: rgb_bits = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r <= 8'h00;
            vga_g <= 8'h00;
            vga_b <= 8'h00;
        end else if (pix_ce) begin
            vga_r <= active_nxt ? {8{rgb_bits[2]}} : 8'h00;
            vga_g <= active_nxt ? {8{rgb_bits[1]}} : 8'h00;
            vga_b <= active_nxt ? {8{rgb_bits[0]}} : 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a small override configuration (A) and one with default
// horizontal timing but a short frame (B), scored cycle-by-cycle against a closed-form raster model.
module tb_vga_timing_gen;

    localparam int A_D = 3, A_HA = 4, A_HFP = 1, A_HS = 2, A_HBP = 1;
    localparam int A_VA = 3, A_VFP = 1, A_VS = 1, A_VBP = 1, A_HP = 1, A_VP = 0;
    localparam int B_D = 2, B_HA = 640, B_HFP = 16, B_HS = 96, B_HBP = 48;
    localparam int B_VA = 6, B_VFP = 2, B_VS = 2, B_VBP = 2, B_HP = 0, B_VP = 0;

    typedef struct packed {
        int d, ha, hfp, hs, hbp, va, vfp, vs, vbp, hp, vp;
    } cfg_t;

    typedef struct packed {
        logic        pix_ce, vga_clk, hsync, vsync, blank, sync, active, line_start, frame_start;
        logic [9:0]  px, py;
        logic [23:0] rgb;
    } obs_t;

    localparam cfg_t CFG_A = '{A_D, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_HP, A_VP};
    localparam cfg_t CFG_B = '{B_D, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_HP, B_VP};

    logic clk;
    logic rst_a, en_a, rst_b, en_b;

    logic       a_pix_ce, a_vga_clk, a_hsync, a_vsync, a_blank, a_sync, a_active, a_ls, a_fs;
    logic [9:0] a_pixelx, a_pixely;
    logic       b_pix_ce, b_vga_clk, b_hsync, b_vsync, b_blank, b_sync, b_active, b_ls, b_fs;
    logic [9:0] b_pixelx, b_pixely;
`ifdef VGA_TESTPAT_EN
    logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int k_a = 0, k_b = 0;
    logic last_a = 1'b0, last_b = 1'b0;
    obs_t q_a[$];
    obs_t q_b[$];

    int fs_last_a = -1, fs_prev_a = -1, ls_last_a = -1, ls_prev_a = -1, pce_last_a = -1, pce_prev_a = -1;
    int fs_last_b = -1, fs_prev_b = -1, ls_last_b = -1, ls_prev_b = -1, pce_last_b = -1, pce_prev_b = -1;
    int fs_cnt_b = 0;
    int hs_low_acc = 0, vs_low_acc = 0, bl_low_acc = 0;
    int hs_low_frm = -1, vs_low_frm = -1, bl_low_frm = -1;

    vga_timing_gen #(
        .CLK_DIV(A_D), .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(A_HP), .VS_POL(A_VP), .CW(10)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .pix_ce(a_pix_ce), .vga_clk(a_vga_clk),
        .hsync(a_hsync), .vsync(a_vsync), .blank(a_blank), .sync(a_sync),
        .pixelx(a_pixelx), .pixely(a_pixely), .active(a_active),
        .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TESTPAT_EN
        , .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(B_D), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(B_HP), .VS_POL(B_VP), .CW(10)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .pix_ce(b_pix_ce), .vga_clk(b_vga_clk),
        .hsync(b_hsync), .vsync(b_vsync), .blank(b_blank), .sync(b_sync),
        .pixelx(b_pixelx), .pixely(b_pixely), .active(b_active),
        .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TESTPAT_EN
        , .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] colour(input int bar);
        case (bar)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // k = enabled clock edges since reset; the raster position follows directly from it.
    function automatic obs_t model(input cfg_t c, input int k, input logic en_now, input logic last_en);
        obs_t o;
        int ht, vt, div, p, h, v;
        ht  = c.ha + c.hfp + c.hs + c.hbp;
        vt  = c.va + c.vfp + c.vs + c.vbp;
        div = k % c.d;
        p   = k / c.d;
        h   = p % ht;
        v   = (p / ht) % vt;
        o = '0;
        o.px          = 10'(h);
        o.py          = 10'(v);
        o.pix_ce      = en_now && (div == c.d - 1);
        o.vga_clk     = (div >= c.d / 2);
        o.active      = (h < c.ha) && (v < c.va);
        o.blank       = o.active;
        o.sync        = 1'b0;
        o.hsync       = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? (c.hp != 0) : (c.hp == 0);
        o.vsync       = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? (c.vp != 0) : (c.vp == 0);
        o.line_start  = last_en && (k > 0) && (div == 0) && (h == 0);
        o.frame_start = o.line_start && (v == 0);
        o.rgb         = o.active ? colour((h * 8) / c.ha) : 24'h000000;
        return o;
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o = '0;
        o.pix_ce = a_pix_ce; o.vga_clk = a_vga_clk; o.hsync = a_hsync; o.vsync = a_vsync;
        o.blank = a_blank; o.sync = a_sync; o.active = a_active;
        o.line_start = a_ls; o.frame_start = a_fs; o.px = a_pixelx; o.py = a_pixely;
`ifdef VGA_TESTPAT_EN
        o.rgb = {a_r, a_g, a_b};
`endif
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o = '0;
        o.pix_ce = b_pix_ce; o.vga_clk = b_vga_clk; o.hsync = b_hsync; o.vsync = b_vsync;
        o.blank = b_blank; o.sync = b_sync; o.active = b_active;
        o.line_start = b_ls; o.frame_start = b_fs; o.px = b_pixelx; o.py = b_pixely;
`ifdef VGA_TESTPAT_EN
        o.rgb = {b_r, b_g, b_b};
`endif
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                   tag, observed, observed, expected, expected, cyc);
        end
    endtask

    task automatic compare(input string who, input obs_t got, input obs_t want);
        chk({who, ".pix_ce"},      32'(got.pix_ce),      32'(want.pix_ce));
        chk({who, ".vga_clk"},     32'(got.vga_clk),     32'(want.vga_clk));
        chk({who, ".hsync"},       32'(got.hsync),       32'(want.hsync));
        chk({who, ".vsync"},       32'(got.vsync),       32'(want.vsync));
        chk({who, ".blank"},       32'(got.blank),       32'(want.blank));
        chk({who, ".sync"},        32'(got.sync),        32'(want.sync));
        chk({who, ".active"},      32'(got.active),      32'(want.active));
        chk({who, ".line_start"},  32'(got.line_start),  32'(want.line_start));
        chk({who, ".frame_start"}, 32'(got.frame_start), 32'(want.frame_start));
        chk({who, ".pixelx"},      32'(got.px),          32'(want.px));
        chk({who, ".pixely"},      32'(got.py),          32'(want.py));
`ifdef VGA_TESTPAT_EN
        chk({who, ".rgb"},         32'(got.rgb),         32'(want.rgb));
`endif
    endtask

    // Drive one clock of stimulus; expectations are queued at drive time and scored after the edge.
    task automatic tick(input logic ra, input logic ea, input logic rb, input logic eb);
        obs_t got;
        rst_a = ra; en_a = ea; rst_b = rb; en_b = eb;
        k_a    = ra ? 0 : (ea ? k_a + 1 : k_a);
        last_a = !ra && ea;
        k_b    = rb ? 0 : (eb ? k_b + 1 : k_b);
        last_b = !rb && eb;
        q_a.push_back(model(CFG_A, k_a, ea, last_a));
        q_b.push_back(model(CFG_B, k_b, eb, last_b));
        @(posedge clk);
        cyc++;
        #1;
        got = get_a();
        compare("A", got, q_a.pop_front());
        if (got.frame_start) begin fs_prev_a = fs_last_a; fs_last_a = cyc; end
        if (got.line_start)  begin ls_prev_a = ls_last_a; ls_last_a = cyc; end
        if (got.pix_ce)      begin pce_prev_a = pce_last_a; pce_last_a = cyc; end
        got = get_b();
        compare("B", got, q_b.pop_front());
        if (got.frame_start) begin
            if (fs_cnt_b > 0) begin
                hs_low_frm = hs_low_acc; vs_low_frm = vs_low_acc; bl_low_frm = bl_low_acc;
            end
            hs_low_acc = 0; vs_low_acc = 0; bl_low_acc = 0;
            fs_cnt_b++;
            fs_prev_b = fs_last_b; fs_last_b = cyc;
        end
        if (got.line_start) begin ls_prev_b = ls_last_b; ls_last_b = cyc; end
        if (got.pix_ce)     begin pce_prev_b = pce_last_b; pce_last_b = cyc; end
        if (!got.hsync) hs_low_acc++;
        if (!got.vsync) vs_low_acc++;
        if (!got.blank) bl_low_acc++;
    endtask

    initial begin
        int fs_before;
        int rst_cyc;
        rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;

        repeat (3) tick(1, 1, 1, 1);
        chk("A.reset_pixelx",  32'(a_pixelx),  0);
        chk("A.reset_hsync",   32'(a_hsync),   0);
        chk("A.reset_vsync",   32'(a_vsync),   1);
        chk("A.reset_blank",   32'(a_blank),   1);
        chk("A.reset_vga_clk", 32'(a_vga_clk), 0);
        chk("B.reset_hsync",   32'(b_hsync),   1);
        chk("B.reset_vsync",   32'(b_vsync),   1);

        repeat (300) tick(0, 1, 1, 1);
        chk("A.frame_period",  fs_last_a - fs_prev_a, 144);
        chk("A.line_period",   ls_last_a - ls_prev_a, 24);
        chk("A.pix_ce_period", pce_last_a - pce_prev_a, 3);

        // Pause mid-frame for 37 clocks.
        for (int i = 0; i < 200 && !(a_pixelx == 10'd5 && a_pixely == 10'd2); i++) tick(0, 1, 1, 1);
        chk("A.pause_reach", 32'(a_pixelx == 10'd5 && a_pixely == 10'd2), 1);
        fs_before = fs_last_a;
        repeat (37) tick(0, 0, 1, 1);
        chk("A.pause_pixelx", 32'(a_pixelx), 5);
        chk("A.pause_pixely", 32'(a_pixely), 2);
        chk("A.pause_pix_ce", 32'(a_pix_ce), 0);
        for (int i = 0; i < 300 && fs_last_a == fs_before; i++) tick(0, 1, 1, 1);
        chk("A.pause_frame_delay", fs_last_a - fs_before, 144 + 37);

        // Mid-frame, mid-pixel reset.
        for (int i = 0; i < 200 && a_pixely != 10'd3; i++) tick(0, 1, 1, 1);
        chk("A.rst_reach", 32'(a_pixely), 3);
        tick(0, 1, 1, 1);
        tick(1, 1, 1, 1);
        rst_cyc   = cyc;
        fs_before = fs_last_a;
        chk("A.rst_pixelx",  32'(a_pixelx),  0);
        chk("A.rst_pixely",  32'(a_pixely),  0);
        chk("A.rst_vga_clk", 32'(a_vga_clk), 0);
        chk("A.rst_hsync",   32'(a_hsync),   0);
        chk("A.rst_vsync",   32'(a_vsync),   1);
        chk("A.rst_blank",   32'(a_blank),   1);
        chk("A.rst_fs",      32'(a_fs),      0);
        for (int i = 0; i < 300 && fs_last_a == fs_before; i++) tick(0, 1, 1, 1);
        chk("A.rst_first_frame", fs_last_a - rst_cyc, 144);

        // Default horizontal timing with a 12-line frame.
        for (int i = 0; i < 40000 && fs_cnt_b < 2; i++) tick(0, 1, 0, 1);
        chk("B.frame_count",   fs_cnt_b, 2);
        chk("B.frame_period",  fs_last_b - fs_prev_b, 19200);
        chk("B.line_period",   ls_last_b - ls_prev_b, 1600);
        chk("B.pix_ce_period", pce_last_b - pce_prev_b, 2);
        chk("B.hsync_low_clks", hs_low_frm, 192 * 12);
        chk("B.vsync_low_clks", vs_low_frm, 1600 * 2);
        chk("B.blank_low_clks", bl_low_frm, 19200 - 1280 * 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
